// File: rtl/spi_xip_pkg.sv
// Shared definitions for the SPI execute-in-place APB bridge: FSM state
// encoding, flash opcodes, default XIP window and small data helpers.
package spi_xip_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_DATA  = 3'd4,
    ST_DONE  = 3'd5
  } xip_state_e;

  localparam logic [7:0]  OP_READ        = 8'h03;
  localparam logic [7:0]  OP_FAST_READ   = 8'h0B;
  localparam logic [31:0] DEF_FLASH_BASE = 32'h3000_0000;
  localparam logic [31:0] DEF_FLASH_END  = 32'h3fff_ffff;

  // Width of the shifter bit/divider counters and of the outgoing header.
  localparam int CNT_W = 16;
  localparam int TX_W  = 40;

  // Left-aligned outgoing header: opcode, then the word-aligned address
  // truncated to the configured number of address bytes. Anything shifted
  // past the header (dummy bits, data phase) goes out as zero.
  function automatic logic [TX_W-1:0] build_tx(input logic [7:0] cmd,
                                               input logic [31:0] addr,
                                               input int addr_bytes);
    logic [31:0] a;
    a = {addr[31:2], 2'b00};
    if (addr_bytes == 3) a = {a[23:0], 8'h00};
    return {cmd, a};
  endfunction

  // Flash bytes arrive MSB-first; the first byte belongs in bits [7:0].
  function automatic logic [31:0] swap_bytes(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_xip_shifter.sv
// SPI mode-0 bit engine: generates SCK, shifts the header out MSB first,
// samples MISO on each rising SCK edge and pulses done once the last bit
// period has ended.
module spi_xip_shifter
  import spi_xip_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] bit_count,
  input  logic [TX_W-1:0]  tx_word,
  input  logic             miso,
  output logic             sck,
  output logic             mosi,
  output logic [31:0]      rx_word,
  output logic             done
);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

  logic             busy;
  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] bits_left;
  logic [TX_W-1:0]  tx_sr;

  // Half-period timer, SCK toggling, MOSI update on falls, MISO sample on rises.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      sck       <= 1'b0;
      mosi      <= 1'b0;
      done      <= 1'b0;
      div_cnt   <= '0;
      bits_left <= '0;
      tx_sr     <= '0;
      rx_word   <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy      <= 1'b1;
          sck       <= 1'b0;
          div_cnt   <= '0;
          bits_left <= bit_count;
          mosi      <= tx_word[TX_W-1];
          tx_sr     <= {tx_word[TX_W-2:0], 1'b0};
        end
      end else if (div_cnt != DIV_LAST) begin
        div_cnt <= div_cnt + CNT_W'(1);
      end else begin
        div_cnt <= '0;
        if (!sck) begin
          sck     <= 1'b1;
          rx_word <= {rx_word[30:0], miso};
        end else begin
          sck <= 1'b0;
          if (bits_left == CNT_W'(1)) begin
            busy <= 1'b0;
            done <= 1'b1;
            mosi <= 1'b0;
          end else begin
            bits_left <= bits_left - CNT_W'(1);
            mosi      <= tx_sr[TX_W-1];
            tx_sr     <= {tx_sr[TX_W-2:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/spi_xip_apb.sv
// APB slave that maps a memory window onto a SPI NOR flash read.
// Each in-window APB read issues opcode + address (+ dummy) and returns one
// 32-bit word; writes and out-of-window accesses get an immediate error.
// Optional macro SPI_XIP_WORD_CACHE_EN adds a one-word read buffer.
//
// Handshake: an access is in_psel & in_penable seen in IDLE. Errors answer
// combinationally in that same cycle; reads answer with a single-cycle
// in_pready in DONE, with in_prdata zero whenever in_pready is low. Once a
// transfer has started the APB inputs are ignored except that a dropped
// in_psel marks the result for discard.
module spi_xip_apb
  import spi_xip_pkg::*;
#(
  parameter logic [31:0] FLASH_BASE   = DEF_FLASH_BASE,
  parameter logic [31:0] FLASH_END    = DEF_FLASH_END,
  parameter int          SS_NUM       = 8,
  parameter int          SS_IDX       = 0,
  parameter int          CLK_DIV      = 1,
  parameter logic [7:0]  READ_CMD     = OP_READ,
  parameter int          ADDR_BYTES   = 3,
  parameter int          DUMMY_CYCLES = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       in_paddr,
  input  logic              in_psel,
  input  logic              in_penable,
  input  logic [2:0]        in_pprot,
  input  logic              in_pwrite,
  input  logic [31:0]       in_pwdata,
  input  logic [3:0]        in_pstrb,
  output logic              in_pready,
  output logic [31:0]       in_prdata,
  output logic              in_pslverr,
  output logic              spi_sck,
  output logic [SS_NUM-1:0] spi_ss,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output xip_state_e        dbg_state
);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("spi_xip_apb: CLK_DIV must be at least 1");
  end
  if (SS_IDX < 0 || SS_IDX >= SS_NUM) begin : g_bad_ss_idx
    $error("spi_xip_apb: SS_IDX must be within 0..SS_NUM-1");
  end
  if (ADDR_BYTES != 3 && ADDR_BYTES != 4) begin : g_bad_addr_bytes
    $error("spi_xip_apb: ADDR_BYTES must be 3 or 4");
  end

  localparam logic [CNT_W-1:0] TOTAL_BITS = CNT_W'(40 + 8 * ADDR_BYTES + DUMMY_CYCLES);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(7);
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(8 * ADDR_BYTES - 1);
  localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_CYCLES - 1);

  xip_state_e       state;
  logic             ss_active;
  logic             pready_q;
  logic [31:0]      data_q;
  logic             abort;
  logic [CNT_W-1:0] phase_cnt;
  logic             sck_q;

  logic             access, in_window, rd_req, err_req, hit, start;
  logic             sck_fall, deliver, shift_done;
  logic [31:0]      rx_word, hit_data;

  logic unused_inputs;
  assign unused_inputs = ^{in_pprot, in_pwdata, in_pstrb};

  assign access    = in_psel & in_penable;
  assign in_window = (in_paddr >= FLASH_BASE) && (in_paddr <= FLASH_END);
  assign rd_req    = (state == ST_IDLE) & access & ~in_pwrite & in_window;
  assign err_req   = (state == ST_IDLE) & access & (in_pwrite | ~in_window) & ~reset;
  assign start     = rd_req & ~hit;
  assign sck_fall  = sck_q & ~spi_sck;
  assign deliver   = in_psel & ~abort;

`ifdef SPI_XIP_WORD_CACHE_EN
  logic        cache_valid;
  logic [29:0] cache_tag;
  logic [29:0] pend_tag;
  logic [31:0] cache_data;

  assign hit      = rd_req & cache_valid & (cache_tag == in_paddr[31:2]);
  assign hit_data = cache_data;

  // Remember the tag of the read in flight and refill the buffer on delivery.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      pend_tag    <= '0;
      cache_data  <= '0;
    end else begin
      if (start) pend_tag <= in_paddr[31:2];
      if (state == ST_DATA && shift_done && deliver) begin
        cache_valid <= 1'b1;
        cache_tag   <= pend_tag;
        cache_data  <= swap_bytes(rx_word);
      end
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  spi_xip_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .bit_count(TOTAL_BITS),
    .tx_word  (build_tx(READ_CMD, in_paddr, ADDR_BYTES)),
    .miso     (spi_miso),
    .sck      (spi_sck),
    .mosi     (spi_mosi),
    .rx_word  (rx_word),
    .done     (shift_done)
  );

  // Transaction FSM: tracks the phase by counting SCK falls, owns slave
  // select and the registered read response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      ss_active <= 1'b0;
      pready_q  <= 1'b0;
      data_q    <= '0;
      abort     <= 1'b0;
      phase_cnt <= '0;
      sck_q     <= 1'b0;
    end else begin
      sck_q <= spi_sck;
      if (state inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA} && !in_psel) abort <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (hit) begin
            state    <= ST_DONE;
            pready_q <= 1'b1;
            data_q   <= hit_data;
          end else if (start) begin
            state     <= ST_CMD;
            ss_active <= 1'b1;
            abort     <= 1'b0;
            phase_cnt <= '0;
          end
        end
        ST_CMD: begin
          if (sck_fall) begin
            if (phase_cnt == CMD_LAST) begin
              state     <= ST_ADDR;
              phase_cnt <= '0;
            end else begin
              phase_cnt <= phase_cnt + CNT_W'(1);
            end
          end
        end
        ST_ADDR: begin
          if (sck_fall) begin
            if (phase_cnt == ADDR_LAST) begin
              state     <= (DUMMY_CYCLES > 0) ? ST_DUMMY : ST_DATA;
              phase_cnt <= '0;
            end else begin
              phase_cnt <= phase_cnt + CNT_W'(1);
            end
          end
        end
        ST_DUMMY: begin
          if (sck_fall) begin
            if (phase_cnt == DUMMY_LAST) begin
              state     <= ST_DATA;
              phase_cnt <= '0;
            end else begin
              phase_cnt <= phase_cnt + CNT_W'(1);
            end
          end
        end
        ST_DATA: begin
          if (shift_done) begin
            ss_active <= 1'b0;
            phase_cnt <= '0;
            if (deliver) begin
              state    <= ST_DONE;
              pready_q <= 1'b1;
              data_q   <= swap_bytes(rx_word);
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          pready_q <= 1'b0;
          data_q   <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_pready  = pready_q | err_req;
  assign in_pslverr = err_req;
  assign in_prdata  = data_q;
  assign spi_ss     = ss_active ? ~(SS_NUM'(1) << SS_IDX) : '1;
  assign dbg_state  = state;

endmodule
